// File: rtl/clk_period_meter_if.sv
// Bundle for the period meter: the signal under measurement and the results.
// master = side that drives the signal and reads results; slave = the meter.
interface clk_period_meter_if #(
   parameter int CNT_W = 16
);
   logic             sig_i;
   logic [CNT_W-1:0] period_o;
   logic [CNT_W-1:0] high_o;
   logic             valid_o;
   logic             timeout_o;

   modport master (
      output sig_i,
      input  period_o,
      input  high_o,
      input  valid_o,
      input  timeout_o
   );

   modport slave (
      input  sig_i,
      output period_o,
      output high_o,
      output valid_o,
      output timeout_o
   );
endinterface

// File: rtl/clk_period_meter.sv
// Measures period and high time of a slow, asynchronous square wave in
// clk_i cycles. Counters saturate; a stalled input raises timeout_o.
//
// state   | meaning
// --------+-----------------------------------------------
// ST_SYNC | no reference edge yet (after reset or timeout)
// ST_MEAS | counting between two rising edges
module clk_period_meter #(
   parameter int CNT_W = 16
) (
   input  logic               clk_i,
   input  logic               rst_i,
   clk_period_meter_if.slave  mon
);

   localparam logic [0:0]       ST_SYNC = 1'b0;
   localparam logic [0:0]       ST_MEAS = 1'b1;
   localparam logic [CNT_W-1:0] MAX     = '1;
   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

   logic             s1_q, s2_q, s3_q;
   logic [0:0]       state_q, state_d;
   logic [CNT_W-1:0] pcnt_q, pcnt_d;
   logic [CNT_W-1:0] hcnt_q, hcnt_d;
   logic [CNT_W-1:0] period_q, period_d;
   logic [CNT_W-1:0] high_q, high_d;
   logic             valid_q, valid_d;
   logic             timeout_q, timeout_d;
   logic             rise;
   logic             hi;

   // Two-flop synchronizer followed by an edge-detect register
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
         s3_q <= 1'b0;
      end else begin
         s1_q <= mon.sig_i;
         s2_q <= s1_q;
         s3_q <= s2_q;
      end
   end

   assign rise = s2_q & ~s3_q;
   assign hi   = s2_q;

   // Next-state logic: an edge beats a timeout in the same cycle, so a
   // period of exactly MAX still reports instead of timing out
   always_comb begin
      state_d   = state_q;
      pcnt_d    = pcnt_q;
      hcnt_d    = hcnt_q;
      period_d  = period_q;
      high_d    = high_q;
      valid_d   = 1'b0;
      timeout_d = timeout_q;
      if (rise) begin
         if (state_q == ST_MEAS) begin
            period_d = pcnt_q;
            high_d   = hcnt_q;
            valid_d  = 1'b1;
         end
         state_d   = ST_MEAS;
         pcnt_d    = ONE;
         hcnt_d    = ONE;
         timeout_d = 1'b0;
      end else if (pcnt_q == MAX) begin
         state_d   = ST_SYNC;
         timeout_d = 1'b1;
         period_d  = '0;
         high_d    = '0;
      end else begin
         pcnt_d = pcnt_q + ONE;
         if ((state_q == ST_MEAS) && hi && (hcnt_q != MAX)) begin
            hcnt_d = hcnt_q + ONE;
         end
      end
   end

   // State, counters and result registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= ST_SYNC;
         pcnt_q    <= '0;
         hcnt_q    <= '0;
         period_q  <= '0;
         high_q    <= '0;
         valid_q   <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pcnt_q    <= pcnt_d;
         hcnt_q    <= hcnt_d;
         period_q  <= period_d;
         high_q    <= high_d;
         valid_q   <= valid_d;
         timeout_q <= timeout_d;
      end
   end

   assign mon.period_o  = period_q;
   assign mon.high_o    = high_q;
   assign mon.valid_o   = valid_q;
   assign mon.timeout_o = timeout_q;

endmodule

// File: tb/tb_clk_period_meter.sv
// Bench for clk_period_meter: an 8-bit and a 16-bit instance share one input
// and are checked every cycle against an edge-history reference model.
module tb_clk_period_meter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic sig = 1'b0;

   always #5 clk = ~clk;

   clk_period_meter_if #(.CNT_W(8))  if8 ();
   clk_period_meter_if #(.CNT_W(16)) if16 ();

   assign if8.sig_i  = sig;
   assign if16.sig_i = sig;

   clk_period_meter #(.CNT_W(8)) u_dut8 (
      .clk_i (clk),
      .rst_i (rst),
      .mon   (if8)
   );

   clk_period_meter #(.CNT_W(16)) u_dut16 (
      .clk_i (clk),
      .rst_i (rst),
      .mon   (if16)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // The model keeps the sampled input history. The meter sees each sample
   // two edges late; a rising edge of that delayed stream closes a period
   // whose length is the edge distance and whose high time is the number of
   // high samples inside it. A reference older than MAX cycles times out.
   bit xh [0:199999];
   int ecnt     = 0;
   int last_rst = 0;
   bit ready    = 1'b0;
   int mx       [2] = '{255, 65535};
   int exp_per  [2];
   int exp_high [2];
   int exp_val  [2];
   int exp_to   [2];
   bit armed    [2];
   int last_ref [2];

   function automatic bit hval(input int e);
      if (e - 2 <= last_rst) return 1'b0;
      return xh[e-2];
   endfunction

   always @(posedge clk) begin
      int e;
      int s;
      bit r;
      ecnt++;
      e = ecnt;
      xh[e] = sig;
      if (rst) begin
         last_rst = e;
         ready    = 1'b1;
         for (int i = 0; i < 2; i++) begin
            exp_per[i]  = 0;
            exp_high[i] = 0;
            exp_val[i]  = 0;
            exp_to[i]   = 0;
            armed[i]    = 1'b0;
            last_ref[i] = e + 1;
         end
      end else if (ready) begin
         r = hval(e) && !hval(e - 1);
         for (int i = 0; i < 2; i++) begin
            exp_val[i] = 0;
            if (r) begin
               if (armed[i]) begin
                  s = 0;
                  for (int k = last_ref[i]; k < e; k++) s += int'(hval(k));
                  exp_val[i]  = 1;
                  exp_per[i]  = e - last_ref[i];
                  exp_high[i] = s;
               end
               armed[i]    = 1'b1;
               exp_to[i]   = 0;
               last_ref[i] = e;
            end else if (e - last_ref[i] >= mx[i]) begin
               exp_to[i]   = 1;
               exp_per[i]  = 0;
               exp_high[i] = 0;
               armed[i]    = 1'b0;
            end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   int vcnt8 = 0;

   always @(negedge clk) begin
      if (ready) begin
         chk("dut8 valid",    int'(if8.valid_o),    exp_val[0]);
         chk("dut8 period",   int'(if8.period_o),   exp_per[0]);
         chk("dut8 high",     int'(if8.high_o),     exp_high[0]);
         chk("dut8 timeout",  int'(if8.timeout_o),  exp_to[0]);
         chk("dut16 valid",   int'(if16.valid_o),   exp_val[1]);
         chk("dut16 period",  int'(if16.period_o),  exp_per[1]);
         chk("dut16 high",    int'(if16.high_o),    exp_high[1]);
         chk("dut16 timeout", int'(if16.timeout_o), exp_to[1]);
      end
      if (if8.valid_o) vcnt8++;
   end

   // ---------------- stimulus ----------------
   task automatic wave(input int h, input int l, input int n);
      for (int p = 0; p < n; p++) begin
         sig = 1'b1;
         repeat (h) @(negedge clk);
         sig = 1'b0;
         repeat (l) @(negedge clk);
      end
   endtask

   initial begin
      int v0;
      rst = 1'b1;
      sig = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("reset period", int'(if8.period_o), 0);
      chk("reset timeout", int'(if8.timeout_o), 0);

      // divide-by-10: first edge gives no result
      v0 = vcnt8;
      wave(5, 5, 4);
      #1;
      chk("div10 valid count", vcnt8 - v0, 3);
      chk("div10 period", int'(if8.period_o), 10);
      chk("div10 high", int'(if8.high_o), 5);

      // fastest input
      wave(1, 1, 10);
      #1;
      chk("fast period", int'(if8.period_o), 2);
      chk("fast high", int'(if8.high_o), 1);

      // asymmetric duty
      wave(3, 7, 4);
      #1;
      chk("asym period", int'(if8.period_o), 10);
      chk("asym high", int'(if8.high_o), 3);

      // stall, then restart
      sig = 1'b0;
      repeat (300) @(negedge clk);
      #1;
      chk("stall timeout", int'(if8.timeout_o), 1);
      chk("stall period", int'(if8.period_o), 0);
      chk("stall high", int'(if8.high_o), 0);
      chk("stall dut16 period", int'(if16.period_o), 10);
      v0 = vcnt8;
      sig = 1'b1;
      repeat (4) @(negedge clk);
      #1;
      chk("restart timeout", int'(if8.timeout_o), 0);
      chk("restart no valid", vcnt8 - v0, 0);
      @(negedge clk);
      sig = 1'b0;
      repeat (5) @(negedge clk);
      wave(5, 5, 2);
      #1;
      chk("restart valid count", vcnt8 - v0, 2);
      chk("restart period", int'(if8.period_o), 10);

      // period of exactly MAX for the 8-bit counter
      wave(100, 155, 3);
      #1;
      chk("sat period", int'(if8.period_o), 255);
      chk("sat high", int'(if8.high_o), 100);
      chk("sat timeout", int'(if8.timeout_o), 0);

      // one cycle beyond MAX: only the 16-bit meter reports it
      wave(100, 156, 2);
      #1;
      chk("over16 period", int'(if16.period_o), 256);

      // reset in the middle of a period
      wave(5, 5, 3);
      sig = 1'b1;
      repeat (5) @(negedge clk);
      sig = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("midrst period", int'(if8.period_o), 0);
      chk("midrst high", int'(if8.high_o), 0);
      chk("midrst valid", int'(if8.valid_o), 0);
      chk("midrst timeout", int'(if8.timeout_o), 0);
      v0 = vcnt8;
      @(negedge clk);
      repeat (2) @(negedge clk);
      wave(5, 5, 3);
      #1;
      chk("midrst valid count", vcnt8 - v0, 2);
      chk("midrst resumed period", int'(if8.period_o), 10);

      // randomized waveforms, occasional long stalls and resets
      @(negedge clk);
      for (int t = 0; t < 60; t++) begin
         wave($urandom_range(1, 30), $urandom_range(1, 30), $urandom_range(1, 3));
         if ($urandom_range(0, 9) == 0) begin
            sig = 1'b0;
            repeat ($urandom_range(200, 320)) @(negedge clk);
         end
         if ($urandom_range(0, 14) == 0) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
         end
      end

      repeat (5) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
